// File: rtl/npc_axi_pkg.sv
// Shared AXI4-Lite definitions for the fetch/LSU-side memory slave.
// Holds response codes, the read/write FSM state encodings, the captured
// write-beat payload and the address range helper.
package npc_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  // Write beat held between AW/W capture and commit.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_beat_t;

  // True when base <= addr < base + span; 33-bit math avoids wrap at the top.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] span);
    logic [32:0] off;
    off = 33'(addr) - 33'(base);
    return (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/axil_lat_cnt.sv
// Loadable 4-bit down-counter pacing the access latency of one FSM.
// Ports: clk/rst (async active-high), load + load_val preset the count,
// dec steps it down (saturating at 0), done is high while the count is 1.
module axil_lat_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Final wait cycle: the owning FSM moves to its response state on this edge.
  assign done = (cnt == 4'd1);

endmodule

// File: rtl/axil_sram.sv
// AXI4-Lite slave word memory with a fixed, programmable response latency.
// Independent read and write FSMs allow one read and one write in flight.
// Ports: clk, rst (async active-high); AR (araddr/arvalid/arready),
// R (rdata/rresp/rvalid/rready), AW (awaddr/awvalid/awready),
// W (wdata/wstrb/wvalid/wready), B (bresp/bvalid/bready).
module axil_sram
  import npc_axi_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam logic [3:0]  LAT_W    = 4'(LAT);
  localparam bit          LAT_ZERO = (LAT == 0);

  logic [31:0] mem [DEPTH];

  rd_state_t   rd_state, rd_state_d;
  logic        rd_load, rd_dec, rd_done;
  logic        ar_fire_c, rd_sample_c, rd_ok_c;
  logic [31:0] araddr_q, rd_addr_c;
  logic [AW-1:0] rd_idx_c;
  logic        arready_d, rvalid_d;

  wr_state_t   wr_state, wr_state_d;
  logic        wr_load, wr_dec, wr_done;
  logic        aw_fire_c, w_fire_c, wr_commit_c, wr_ok_c;
  logic        aw_held, w_held, aw_held_d, w_held_d;
  wr_beat_t    beat_q, beat_c;
  logic [AW-1:0] wr_idx_c;
  logic        awready_d, wready_d, bvalid_d;

  axil_lat_cnt u_rd_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_load),
    .load_val (LAT_W),
    .dec      (rd_dec),
    .done     (rd_done)
  );

  axil_lat_cnt u_wr_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (wr_load),
    .load_val (LAT_W),
    .dec      (wr_dec),
    .done     (wr_done)
  );

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
    end else begin
      rd_state <= rd_state_d;
      wr_state <= wr_state_d;
      aw_held  <= aw_held_d;
      w_held   <= w_held_d;
    end
  end

  // Read next-state
  always_comb begin
    rd_state_d = rd_state;
    rd_load    = 1'b0;
    rd_dec     = 1'b0;
    ar_fire_c  = arvalid && arready;
    case (rd_state)
      R_IDLE: begin
        if (ar_fire_c) begin
          rd_load    = 1'b1;
          rd_state_d = LAT_ZERO ? R_RESP : R_WAIT;
        end
      end
      R_WAIT: begin
        rd_dec = 1'b1;
        if (rd_done) rd_state_d = R_RESP;
      end
      R_RESP: begin
        if (rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write next-state; AW and W are tracked separately until both are held.
  always_comb begin
    wr_state_d = wr_state;
    wr_load    = 1'b0;
    wr_dec     = 1'b0;
    aw_fire_c  = awvalid && awready;
    w_fire_c   = wvalid && wready;
    aw_held_d  = aw_held;
    w_held_d   = w_held;
    case (wr_state)
      W_IDLE: begin
        aw_held_d = aw_held || aw_fire_c;
        w_held_d  = w_held || w_fire_c;
        if (aw_held_d && w_held_d) begin
          wr_load    = 1'b1;
          wr_state_d = LAT_ZERO ? W_RESP : W_WAIT;
        end
      end
      W_WAIT: begin
        wr_dec = 1'b1;
        if (wr_done) wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (bready) begin
          wr_state_d = W_IDLE;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      default: begin
        wr_state_d = W_IDLE;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
      end
    endcase
  end

  // Output / datapath decode; handshake outputs are registered from next state.
  always_comb begin
    arready_d   = (rd_state_d == R_IDLE);
    rvalid_d    = (rd_state_d == R_RESP);
    awready_d   = (wr_state_d == W_IDLE) && !aw_held_d;
    wready_d    = (wr_state_d == W_IDLE) && !w_held_d;
    bvalid_d    = (wr_state_d == W_RESP);

    // Same-cycle capture bypasses the holding registers so LAT=0 works.
    rd_addr_c   = ar_fire_c ? araddr : araddr_q;
    rd_sample_c = (rd_state_d == R_RESP) && (rd_state != R_RESP);
    rd_ok_c     = addr_in_range(rd_addr_c, BASE, SPAN);
    rd_idx_c    = AW'((rd_addr_c - BASE) >> 2);

    beat_c = beat_q;
    if (aw_fire_c) beat_c.addr = awaddr;
    if (w_fire_c) begin
      beat_c.data = wdata;
      beat_c.strb = wstrb;
    end
    wr_commit_c = (wr_state_d == W_RESP) && (wr_state != W_RESP);
    wr_ok_c     = addr_in_range(beat_c.addr, BASE, SPAN);
    wr_idx_c    = AW'((beat_c.addr - BASE) >> 2);
  end

  // Registered outputs and captured request fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready  <= 1'b1;
      awready  <= 1'b1;
      wready   <= 1'b1;
      rvalid   <= 1'b0;
      bvalid   <= 1'b0;
      rdata    <= 32'd0;
      rresp    <= RESP_OKAY;
      bresp    <= RESP_OKAY;
      araddr_q <= 32'd0;
      beat_q   <= '0;
    end else begin
      arready  <= arready_d;
      awready  <= awready_d;
      wready   <= wready_d;
      rvalid   <= rvalid_d;
      bvalid   <= bvalid_d;
      araddr_q <= rd_addr_c;
      beat_q   <= beat_c;
      // Sampled with the pre-commit array contents on a same-edge write.
      if (rd_sample_c) begin
        rdata <= rd_ok_c ? mem[rd_idx_c] : 32'd0;
        rresp <= rd_ok_c ? RESP_OKAY : RESP_DECERR;
      end
      if (wr_commit_c) begin
        bresp <= wr_ok_c ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  // Storage array: byte-enabled write port, not reset
  always_ff @(posedge clk) begin
    if (wr_commit_c && wr_ok_c) begin
      for (int b = 0; b < 4; b++) begin
        if (beat_c.strb[b]) mem[wr_idx_c][8*b +: 8] <= beat_c.data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axil_sram.sv
// Directed self-checking bench for axil_sram. Two instances share all
// inputs: dut (LAT=2) and dut_z (LAT=0); sel0 picks whose outputs are checked.
module tb_axil_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr = 32'd0, awaddr = 32'd0, wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0;
  logic        rready = 1'b1, bready = 1'b1;

  logic        arready_a, rvalid_a, awready_a, wready_a, bvalid_a;
  logic [31:0] rdata_a;
  logic [1:0]  rresp_a, bresp_a;
  logic        arready_z, rvalid_z, awready_z, wready_z, bvalid_z;
  logic [31:0] rdata_z;
  logic [1:0]  rresp_z, bresp_z;

  logic        sel0 = 1'b0;
  logic        arready_o, rvalid_o, awready_o, wready_o, bvalid_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o, bresp_o;

  assign arready_o = sel0 ? arready_z : arready_a;
  assign rvalid_o  = sel0 ? rvalid_z  : rvalid_a;
  assign awready_o = sel0 ? awready_z : awready_a;
  assign wready_o  = sel0 ? wready_z  : wready_a;
  assign bvalid_o  = sel0 ? bvalid_z  : bvalid_a;
  assign rdata_o   = sel0 ? rdata_z   : rdata_a;
  assign rresp_o   = sel0 ? rresp_z   : rresp_a;
  assign bresp_o   = sel0 ? bresp_z   : bresp_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_sram #(.BASE(32'h8000_0000), .DEPTH(4096), .LAT(2)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready_a),
    .rdata(rdata_a), .rresp(rresp_a), .rvalid(rvalid_a), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready_a),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_a),
    .bresp(bresp_a), .bvalid(bvalid_a), .bready(bready)
  );

  axil_sram #(.BASE(32'h8000_0000), .DEPTH(4096), .LAT(0)) dut_z (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready_z),
    .rdata(rdata_z), .rresp(rresp_z), .rvalid(rvalid_z), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready_z),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_z),
    .bresp(bresp_z), .bvalid(bvalid_z), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // AW and W in the same cycle; lat counts cycles from the handshake to bvalid.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 1;
    while (!bvalid_o && lat < 20) begin
      step();
      lat++;
    end
    resp = bresp_o;
    step();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
    araddr = a; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid_o && lat < 20) begin
      step();
      lat++;
    end
    d = rdata_o;
    resp = rresp_o;
    step();
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog timeout");
    $fatal(1, "bench stopped by watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    logic        seen;

    // Async reset with no clock edge yet
    #2 rst = 1'b1;
    #2;
    chk("rst_arready", 32'(arready_o), 32'd1);
    chk("rst_awready", 32'(awready_o), 32'd1);
    chk("rst_wready",  32'(wready_o),  32'd1);
    chk("rst_rvalid",  32'(rvalid_o),  32'd0);
    chk("rst_bvalid",  32'(bvalid_o),  32'd0);
    chk("rst_rdata",   rdata_o,        32'd0);
    chk("rst_rresp",   32'(rresp_o),   32'd0);
    chk("rst_bresp",   32'(bresp_o),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Full-word write then readback, LAT=2
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r, lat);
    chk("wr1_lat",   32'(lat), 32'd3);
    chk("wr1_bresp", 32'(r),   32'd0);
    do_read(32'h8000_0010, d, r, lat);
    chk("rd1_lat",   32'(lat), 32'd3);
    chk("rd1_rdata", d,        32'hDEAD_BEEF);
    chk("rd1_rresp", 32'(r),   32'd0);

    // Partial strobe merge; addr[1:0] ignored on the second write
    do_write(32'h8000_0020, 32'hAABB_CCDD, 4'hF, r, lat);
    do_write(32'h8000_0023, 32'h1122_3344, 4'b0101, r, lat);
    chk("strb_bresp", 32'(r), 32'd0);
    do_read(32'h8000_0020, d, r, lat);
    chk("strb_rdata", d, 32'hAA22_CC44);

    // W two cycles before AW, then bready stalled for 5 cycles
    bready = 1'b0;
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("wfirst_wready",  32'(wready_o),  32'd0);
    chk("wfirst_awready", 32'(awready_o), 32'd1);
    step();
    awaddr = 32'h8000_0030; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    lat = 1;
    while (!bvalid_o && lat < 20) begin
      step();
      lat++;
    end
    chk("wfirst_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid", 32'(bvalid_o), 32'd1);
      chk("stall_bresp",  32'(bresp_o),  32'd0);
      step();
    end
    bready = 1'b1;
    step();
    chk("stall_release", 32'(bvalid_o), 32'd0);
    do_read(32'h8000_0030, d, r, lat);
    chk("wfirst_rdata", d, 32'h0BAD_F00D);

    // Out-of-range accesses and range edges
    do_write(32'h8000_0050, 32'h5555_AAAA, 4'hF, r, lat);
    do_write(32'h8000_0000, 32'h1234_5678, 4'hF, r, lat);
    do_write(32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, r, lat);
    chk("edge_bresp", 32'(r), 32'd0);
    do_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, r, lat);
    chk("oor_bresp", 32'(r), 32'd3);
    do_read(32'h7FFF_FFFC, d, r, lat);
    chk("oor_rresp", 32'(r), 32'd3);
    chk("oor_rdata", d,      32'd0);
    do_read(32'h8000_3FFC, d, r, lat);
    chk("edge_rdata", d,      32'hCAFE_F00D);
    chk("edge_rresp", 32'(r), 32'd0);
    do_read(32'h8000_0000, d, r, lat);
    chk("oor_nowrite", d, 32'h1234_5678);

    // Reset while both FSMs are waiting
    araddr = 32'h8000_0050; arvalid = 1'b1;
    awaddr = 32'h8000_0050; awvalid = 1'b1;
    wdata = 32'h0000_0000; wstrb = 4'hF; wvalid = 1'b1;
    step();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("wait_arready", 32'(arready_o), 32'd0);
    chk("wait_awready", 32'(awready_o), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("abort_arready", 32'(arready_o), 32'd1);
    chk("abort_awready", 32'(awready_o), 32'd1);
    chk("abort_wready",  32'(wready_o),  32'd1);
    chk("abort_rdata",   rdata_o,        32'd0);
    chk("abort_bresp",   32'(bresp_o),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | rvalid_o | bvalid_o;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    do_read(32'h8000_0050, d, r, lat);
    chk("abort_word", d, 32'h5555_AAAA);

    // LAT=0: same-edge read sample and write commit
    sel0 = 1'b1;
    do_write(32'h8000_0040, 32'h1111_1111, 4'hF, r, lat);
    chk("z_wr_lat", 32'(lat), 32'd1);
    araddr = 32'h8000_0040; arvalid = 1'b1;
    awaddr = 32'h8000_0040; awvalid = 1'b1;
    wdata = 32'h2222_2222; wstrb = 4'hF; wvalid = 1'b1;
    step();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("z_hz_rvalid", 32'(rvalid_o), 32'd1);
    chk("z_hz_bvalid", 32'(bvalid_o), 32'd1);
    chk("z_hz_rdata",  rdata_o,       32'h1111_1111);
    chk("z_hz_bresp",  32'(bresp_o),  32'd0);
    step();
    do_read(32'h8000_0040, d, r, lat);
    chk("z_rd_lat",   32'(lat), 32'd1);
    chk("z_rd_rdata", d,        32'h2222_2222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_sram.md
# axil_sram

AXI4-Lite slave memory sitting directly downstream of the instruction-fetch and load/store units. It serves their read-address, read-data, write-address, write-data and write-response channels from an internal word array, with a programmable fixed access latency. Independent read and write FSMs let a fetch and a store be in flight at the same time.

## Interface
Parameters:
- `BASE`, 32'h8000_0000, byte address of word 0
- `DEPTH`, 4096, number of 32-bit words (power of two)
- `LAT`, 2, cycles between address/data capture and response (0..15)

Ports:
- `clk` in 1: clock; all logic on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `araddr` in 32: read byte address
- `arvalid` in 1 / `arready` out 1: read-address handshake
- `rdata` out 32: read data
- `rresp` out 2: read response
- `rvalid` out 1 / `rready` in 1: read-data handshake
- `awaddr` in 32: write byte address
- `awvalid` in 1 / `awready` out 1: write-address handshake
- `wdata` in 32: write data
- `wstrb` in 4: byte enables, bit i covers `wdata[8i+7:8i]`
- `wvalid` in 1 / `wready` out 1: write-data handshake
- `bresp` out 2: write response
- `bvalid` out 1 / `bready` in 1: write-response handshake

## Operation
- Address decode:
  - Index = `(addr - BASE) >> 2`, truncated to log2(DEPTH) bits. `addr[1:0]` is ignored.
  - In range when `BASE <= addr < BASE + 4*DEPTH`. Otherwise the access is out of range.
- Read FSM, states R_IDLE → R_WAIT → R_RESP → R_IDLE:
  - R_IDLE: `arready=1`. When `arvalid` is high, capture `araddr`, load the counter with LAT and go to R_WAIT. If LAT=0, go directly to R_RESP.
  - R_WAIT: decrement the counter. When it reaches 1, go to R_RESP.
  - Entering R_RESP: sample the array. `rdata` = word, `rresp` = OKAY (2'b00). If out of range, `rdata` = 0 and `rresp` = DECERR (2'b11).
  - R_RESP: `rvalid=1`. `rdata`/`rresp` are held stable until `rready`. The handshake returns the FSM to R_IDLE.
- Write FSM, states W_IDLE → W_WAIT → W_RESP → W_IDLE:
  - W_IDLE: `awready` and `wready` are each 1 until their own beat has been captured. AW and W may arrive in either order or in the same cycle.
  - When both beats are held, load the counter with LAT and go to W_WAIT. If LAT=0, go directly to W_RESP.
  - Entering W_RESP: commit the bytes selected by `wstrb` to the array. If out of range, no write occurs and `bresp` = DECERR; otherwise `bresp` = OKAY.
  - W_RESP: `bvalid=1` until `bready`, then go to W_IDLE.
- Hazard: if a read samples and a write commits the same word in the same cycle, the read returns the pre-write data. A read sampled later sees the write.
- The array is not reset.

## Timing
- Reset values: `arready=1`, `awready=1`, `wready=1`, `rvalid=0`, `bvalid=0`, `rdata=0`, `rresp=0`, `bresp=0`. Both FSMs reset to IDLE.
- Read latency: `rvalid` rises LAT+1 cycles after the AR handshake edge.
- Write latency: `bvalid` rises LAT+1 cycles after the later of the AW and W handshakes.
- One outstanding read and one outstanding write at a time. `arready=0` outside R_IDLE.
- A stalled `rready`/`bready` holds the response indefinitely with no data change.
- Reset asserted mid-transaction aborts it: no response is issued, and a write not yet committed is discarded.

## Structure
- Shared package `npc_axi_pkg`:
  - `RESP_OKAY` and `RESP_DECERR` constants
  - `rd_state_t` and `wr_state_t` enums
- One sub-module, `axil_lat_cnt`: 4-bit loadable down-counter with a `done` output. Instantiated once per FSM.
- Array: plain register array, one write port with byte enables, one asynchronous read port sampled into `rdata`.

## Test plan
- LAT=2, write 0xDEADBEEF to 0x8000_0010 with `wstrb`=4'hF, then read it back → `bvalid` 3 cycles after the W beat, `bresp`=0, `rdata`=0xDEADBEEF, `rvalid` 3 cycles after AR.
- Write `wstrb`=4'b0101, data 0x11223344, over a word holding 0xAABBCCDD → readback 0xAA22CC44.
- W beat 2 cycles before AW, then `bready` held low for 5 cycles → write commits once, `bvalid` is held, and `bresp` stays stable.
- Read at 0x7FFF_FFFC and write at `BASE+4*DEPTH` → `rresp`=2'b11, `rdata`=0, `bresp`=2'b11, array unchanged.
- LAT=0, read and write to the same word issued so they sample/commit in the same cycle → read returns the old value; a following read returns the new value.
- Assert `rst` while in R_WAIT and W_WAIT → outputs go to their reset values asynchronously, no `rvalid`/`bvalid`, and the target word is unchanged.
